// File: rtl/shift_pkg.sv
// shift_pkg: op encodings, FSM state codes and step size shared by the shift sequencer.
package shift_pkg;
   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRL  = 2'b01;
   localparam logic [1:0] OP_SRA  = 2'b10;
   localparam logic [1:0] OP_ROTR = 2'b11;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam int COARSE_STEP = 4;
endpackage

// File: rtl/shift_step.sv
// shift_step: one combinational shift step of 1 or COARSE_STEP bits for SLL/SRL/SRA/ROTR.
module shift_step
   import shift_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0] data,
   input  logic [1:0]   op,
   input  logic         coarse_sel,
   output logic [W-1:0] shifted
);
   localparam int K = COARSE_STEP;
   logic [W-1:0] by1, byk;
   // SRA fills from the current MSB; the sign never changes across steps
   always_comb begin
      by1 = op == OP_SLL ? {data[W-2:0], 1'b0}
          : op == OP_SRL ? {1'b0, data[W-1:1]}
          : op == OP_SRA ? {data[W-1], data[W-1:1]}
          :                {data[0], data[W-1:1]};
      byk = op == OP_SLL ? {data[W-K-1:0], {K{1'b0}}}
          : op == OP_SRL ? {{K{1'b0}}, data[W-1:K]}
          : op == OP_SRA ? {{K{data[W-1]}}, data[W-1:K]}
          :                {data[K-1:0], data[W-1:K]};
      shifted = coarse_sel ? byk : by1;
   end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle SLL/SRL/SRA/ROTR unit stepping coarse then fine, with start/busy/done handshake.
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ENABLE_COARSE = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [4:0]            shamt,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);
   logic [1:0]            state_q, state_d, op_q, op_d;
   logic [4:0]            cnt_q, cnt_d, dec;
   logic [DATA_WIDTH-1:0] data_q, data_d, result_q, result_d, step_data;
   logic                  coarse;

   assign coarse = (ENABLE_COARSE != 0) && (cnt_q >= 5'(COARSE_STEP));
   assign dec    = coarse ? 5'(COARSE_STEP) : 5'd1;

   shift_step #(.W(DATA_WIDTH)) u_step (
      .data       (data_q),
      .op         (op_q),
      .coarse_sel (coarse),
      .shifted    (step_data)
   );

   // result is loaded only on the transition into DONE, since DONE always exits to IDLE
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      if (state_q == ST_IDLE && start) begin
         data_d  = data_in;
         cnt_d   = shamt;
         op_d    = op;
         state_d = shamt == 5'd0 ? ST_DONE : ST_SHIFT;
      end else if (state_q == ST_SHIFT) begin
         data_d  = step_data;
         cnt_d   = cnt_q - dec;
         state_d = cnt_d == 5'd0 ? ST_DONE : ST_SHIFT;
      end else if (state_q == ST_DONE) begin
         state_d = ST_IDLE;
      end
      result_d = state_d == ST_DONE ? data_d : result_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         data_q   <= '0;
         cnt_q    <= '0;
         op_q     <= OP_SLL;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         result_q <= result_d;
      end
   end

   assign busy   = state_q != ST_IDLE;
   assign done   = state_q == ST_DONE;
   assign result = result_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed checks of coarse and fine-only shift sequencers.
module tb_shift_sequencer;
   logic        clk, reset_n, start_c, start_f, sel;
   logic [1:0]  op;
   logic [31:0] data_in;
   logic [4:0]  shamt;
   logic        busy_c, done_c, busy_f, done_f, busy_s, done_s;
   logic [31:0] result_c, result_f, result_s;
   int          checks = 0;
   int          errors = 0;

   shift_sequencer #(.DATA_WIDTH(32), .ENABLE_COARSE(1)) dut_c (
      .clk(clk), .reset_n(reset_n), .start(start_c), .op(op), .data_in(data_in),
      .shamt(shamt), .busy(busy_c), .done(done_c), .result(result_c)
   );
   shift_sequencer #(.DATA_WIDTH(32), .ENABLE_COARSE(0)) dut_f (
      .clk(clk), .reset_n(reset_n), .start(start_f), .op(op), .data_in(data_in),
      .shamt(shamt), .busy(busy_f), .done(done_f), .result(result_f)
   );

   assign busy_s   = sel ? busy_f : busy_c;
   assign done_s   = sel ? done_f : done_c;
   assign result_s = sel ? result_f : result_c;

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // called 1ns after an edge with the selected DUT idle; lat counts edges after the accepting one
   task automatic run(input bit fine, input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                      input int n, input logic [31:0] exp, input string tag);
      int lat = 0;
      sel = fine;
      op = o;
      data_in = d;
      shamt = s;
      if (fine) start_f = 1;
      else start_c = 1;
      tick();
      start_c = 0;
      start_f = 0;
      while (!done_s && lat < 64) begin
         tick();
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(n));
      chk({tag, " result"}, result_s, exp);
      tick();
      chk({tag, " single pulse"}, {30'd0, done_s, busy_s}, 32'd0);
      chk({tag, " result held"}, result_s, exp);
   endtask

   initial begin
      int lat;
      reset_n = 0; start_c = 0; start_f = 0; sel = 0;
      op = 2'b00; data_in = '0; shamt = '0;
      #12;
      chk("reset coarse", {busy_c, done_c, result_c}, 34'd0);
      chk("reset fine", {busy_f, done_f, result_f}, 34'd0);
      tick();
      reset_n = 1;
      tick();

      run(0, 2'b01, 32'h8000_0000, 5'd31, 10, 32'h0000_0001, "srl31 coarse");
      run(1, 2'b01, 32'h8000_0000, 5'd31, 31, 32'h0000_0001, "srl31 fine");
      run(0, 2'b10, 32'h8000_0000, 5'd6, 3, 32'hFE00_0000, "sra6");
      run(0, 2'b10, 32'h7FFF_FFF0, 5'd4, 1, 32'h07FF_FFFF, "sra4 pos");
      run(0, 2'b00, 32'h0000_0001, 5'd5, 2, 32'h0000_0020, "sll5");
      run(0, 2'b11, 32'h0000_000F, 5'd4, 1, 32'hF000_0000, "rotr4");
      run(0, 2'b10, 32'hDEAD_BEEF, 5'd0, 0, 32'hDEAD_BEEF, "shamt0 coarse");
      run(1, 2'b11, 32'hDEAD_BEEF, 5'd0, 0, 32'hDEAD_BEEF, "shamt0 fine");
      run(0, 2'b11, 32'h1234_5678, 5'd8, 2, 32'h7812_3456, "rotr8");
      run(0, 2'b10, 32'h8000_0000, 5'd31, 10, 32'hFFFF_FFFF, "sra31 coarse");
      run(1, 2'b10, 32'h9000_0000, 5'd3, 3, 32'hF200_0000, "sra3 fine");
      run(0, 2'b00, 32'hFFFF_FFFF, 5'd31, 10, 32'h8000_0000, "sll31");
      run(1, 2'b11, 32'h0000_0003, 5'd1, 1, 32'h8000_0001, "rotr1 fine");

      // start pulsed while busy must be ignored
      sel = 0;
      op = 2'b01; data_in = 32'h8000_0000; shamt = 5'd31; start_c = 1;
      tick();
      start_c = 0;
      lat = 0;
      repeat (3) begin tick(); lat++; end
      op = 2'b00; data_in = 32'h1234_5678; shamt = 5'd0; start_c = 1;
      tick(); lat++;
      start_c = 0;
      while (!done_c && lat < 64) begin tick(); lat++; end
      chk("busy start latency", 32'(lat), 32'd10);
      chk("busy start result", result_c, 32'h0000_0001);
      tick();
      tick();
      chk("busy start not queued", {30'd0, busy_c, done_c}, 32'd0);

      // start held high through DONE is taken in the following IDLE cycle
      op = 2'b00; data_in = 32'h0000_0001; shamt = 5'd4; start_c = 1;
      tick();
      tick();
      chk("held first done", {31'd0, done_c}, 32'd1);
      chk("held first result", result_c, 32'h0000_0010);
      op = 2'b01; data_in = 32'h0000_0100; shamt = 5'd8;
      tick();
      chk("held idle", {30'd0, busy_c, done_c}, 32'd0);
      tick();
      start_c = 0;
      chk("held accepted", {30'd0, busy_c, done_c}, 32'd2);
      chk("held result stable", result_c, 32'h0000_0010);
      tick();
      chk("held mid", {30'd0, busy_c, done_c}, 32'd2);
      tick();
      chk("held second done", {30'd0, busy_c, done_c}, 32'd3);
      chk("held second result", result_c, 32'h0000_0001);
      tick();

      // asynchronous reset in the middle of a long fine-only shift
      sel = 1;
      op = 2'b01; data_in = 32'h8000_0000; shamt = 5'd31; start_f = 1;
      tick();
      start_f = 0;
      repeat (10) tick();
      chk("pre-abort busy", {31'd0, busy_f}, 32'd1);
      #2 reset_n = 0;
      #1;
      chk("abort immediate", {busy_f, done_f, result_f}, 34'd0);
      lat = 0;
      repeat (3) begin tick(); lat += int'(done_f); end
      reset_n = 1;
      repeat (25) begin tick(); lat += int'(done_f); end
      chk("abort no done", 32'(lat), 32'd0);
      chk("abort result zero", result_f, 32'd0);
      run(1, 2'b11, 32'h0000_0001, 5'd1, 1, 32'h8000_0000, "post-abort fine");
      run(0, 2'b01, 32'hF000_0000, 5'd7, 4, 32'h01E0_0000, "post-abort coarse");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
